// File: rtl/hdmi_audio_pacer_pkg.sv
// Shared types and elaboration-time helpers for the HDMI audio pacer.
// Optional feature macro: HDMI_AUDIO_PACER_TEST_TONE_EN (see hdmi_audio_pacer.sv).
package hdmi_audio_pacer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } pacer_state_t;

    localparam int UNDERRUN_W = 16;

    // Rounded phase increment: round(rate * 2^acc_width / clk_hz).
    function automatic logic [63:0] phase_inc(input int clk_hz, input int rate, input int acc_width);
        logic [63:0] num;
        num = (64'(rate) << acc_width) + 64'(clk_hz / 32'sd2);
        return num / 64'(clk_hz);
    endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock frame FIFO with a show-ahead registered head, level counter and flags.
// Both flags read 1 while in reset so the producer sees no room until reset is released.
module audio_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [LW-1:0]    level_r;
    logic [LW-1:0]    level_nxt_s;
    logic [WIDTH-1:0] rd_data_r;
    logic             full_r;
    logic             empty_r;
    logic             do_wr_s;
    logic             do_rd_s;

    // Qualified handshakes, next read pointer and next level
    always_comb begin
        do_wr_s = wr_en & ~full_r;
        do_rd_s = rd_en & ~empty_r;
        if (do_rd_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   level_nxt_s = level_r + LW'(1'b1);
            2'b01:   level_nxt_s = level_r - LW'(1'b1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Frame storage, kept free of reset so it maps onto RAM
    always_ff @(posedge clk_pixel) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, level, flags and the head-of-queue register
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            level_r   <= '0;
            full_r    <= 1'b1;
            empty_r   <= 1'b1;
            rd_data_r <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
            full_r   <= (level_nxt_s == LW'(DEPTH));
            empty_r  <= (level_nxt_s == '0);
            // A write landing on the next head slot only happens when the queue drains to empty
            if (do_wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
                rd_data_r <= wr_data;
            end else begin
                rd_data_r <= mem_r[rd_ptr_nxt_s];
            end
        end
    end

    assign rd_data = rd_data_r;
    assign level   = level_r;
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/hdmi_audio_pacer.sv
// Paces buffered PCM frames into the HDMI audio path using a fractional phase accumulator.
// Define HDMI_AUDIO_PACER_TEST_TONE_EN to add the test_tone input and the saw-tooth generator.
module hdmi_audio_pacer
    import hdmi_audio_pacer_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 64,
    parameter int PREFILL      = 16,
    parameter int CLK_HZ       = 148_500_000,
    parameter int AUDIO_RATE   = 48000,
    parameter int ACC_WIDTH    = 32,
    localparam int DW = CHANNELS * SAMPLE_WIDTH,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  mute,
`ifdef HDMI_AUDIO_PACER_TEST_TONE_EN
    input  logic                  test_tone,
`endif
    input  logic [DW-1:0]         s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DW-1:0]         audio_sample_word,
    output logic                  sample_strobe,
    output logic                  clk_audio,
    output logic [LW-1:0]         fifo_level,
    output logic [UNDERRUN_W-1:0] underrun_count,
    output logic                  playing
);

    localparam logic [ACC_WIDTH-1:0] INC = ACC_WIDTH'(phase_inc(CLK_HZ, AUDIO_RATE, ACC_WIDTH));

    pacer_state_t          state_r;
    pacer_state_t          state_nxt_s;
    logic [ACC_WIDTH-1:0]  acc_r;
    logic [ACC_WIDTH:0]    sum_s;
    logic                  run_s;
    logic                  tick_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  underrun_s;
    logic                  tone_s;
    logic [DW-1:0]         head_s;
    logic [DW-1:0]         word_nxt_s;
    logic [DW-1:0]         word_r;
    logic                  strobe_r;
    logic                  clk_audio_r;
    logic [UNDERRUN_W-1:0] ucount_r;
    logic                  playing_r;
    logic [LW-1:0]         level_s;
    logic                  full_s;
    logic                  empty_s;

    audio_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .wr_en     (push_s),
        .wr_data   (s_data),
        .rd_en     (pop_s),
        .rd_data   (head_s),
        .level     (level_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign s_ready = ~full_s;
    assign push_s  = s_valid & ~full_s;

`ifdef HDMI_AUDIO_PACER_TEST_TONE_EN
    logic [SAMPLE_WIDTH-1:0] saw_r;
    logic [DW-1:0]           tone_word_s;

    assign tone_s = test_tone;

    // Per-channel saw values, each channel offset by c * 2^(SAMPLE_WIDTH-4)
    always_comb begin
        tone_word_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            tone_word_s[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = saw_r + SAMPLE_WIDTH'(c << (SAMPLE_WIDTH - 4));
        end
    end

    // Saw counter advances once per tone strobe
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            saw_r <= '0;
        end else if (tick_s && tone_s) begin
            saw_r <= saw_r + SAMPLE_WIDTH'(1'b1);
        end
    end
`else
    assign tone_s = 1'b0;
`endif

    // Phase step and audio tick; the accumulator only runs outside IDLE while enabled
    always_comb begin
        if (enable && (state_r != IDLE)) begin
            run_s = 1'b1;
        end else begin
            run_s = 1'b0;
        end
        sum_s  = {1'b0, acc_r} + {1'b0, INC};
        tick_s = run_s & sum_s[ACC_WIDTH];
    end

    // Pop/underrun decision and the next output word
    always_comb begin
        word_nxt_s = word_r;
        pop_s      = 1'b0;
        underrun_s = 1'b0;
        if (tick_s) begin
            if ((state_r == PLAY) && !tone_s) begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    underrun_s = 1'b1;
                end
            end else begin
                pop_s = 1'b0;
            end
            if (mute) begin
                word_nxt_s = '0;
`ifdef HDMI_AUDIO_PACER_TEST_TONE_EN
            end else if (tone_s) begin
                word_nxt_s = tone_word_s;
`endif
            end else if (pop_s) begin
                word_nxt_s = head_s;
            end else begin
                word_nxt_s = word_r;
            end
        end else begin
            word_nxt_s = word_r;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE
    always_comb begin
        state_nxt_s = state_r;
        if (!enable) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:  state_nxt_s = PRIME;
                PRIME: begin
                    if (level_s >= LW'(PREFILL)) begin
                        state_nxt_s = PLAY;
                    end else begin
                        state_nxt_s = PRIME;
                    end
                end
                PLAY: begin
                    if (underrun_s) begin
                        state_nxt_s = PRIME;
                    end else begin
                        state_nxt_s = PLAY;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Accumulator and registered outputs
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            acc_r       <= '0;
            clk_audio_r <= 1'b0;
            strobe_r    <= 1'b0;
            word_r      <= '0;
            ucount_r    <= '0;
            playing_r   <= 1'b0;
        end else begin
            acc_r       <= run_s ? sum_s[ACC_WIDTH-1:0] : '0;
            clk_audio_r <= run_s & ~acc_r[ACC_WIDTH-1];
            strobe_r    <= tick_s;
            word_r      <= word_nxt_s;
            playing_r   <= (state_nxt_s == PLAY);
            if (underrun_s && (ucount_r != '1)) begin
                ucount_r <= ucount_r + UNDERRUN_W'(1'b1);
            end
        end
    end

    assign audio_sample_word = word_r;
    assign sample_strobe     = strobe_r;
    assign clk_audio         = clk_audio_r;
    assign fifo_level        = level_s;
    assign underrun_count    = ucount_r;
    assign playing           = playing_r;

endmodule
